// File: rtl/bus_seq_monitor_pkg.sv
// bus_seq_monitor_pkg: shared state encoding, default widths and increment constant
package bus_seq_monitor_pkg;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_ERR_W = 8;
  localparam logic [DEF_WIDTH-1:0] ONE = DEF_WIDTH'(1'b1);
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    TRACK   = 2'd2
  } state_t;
endpackage

// File: rtl/bus_seq_monitor_if.sv
// bus_seq_monitor_if: counter output bus, word plus drive-enable
interface bus_seq_monitor_if import bus_seq_monitor_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
);
  logic [WIDTH-1:0] din;
  logic             din_oe;
  modport master (output din, din_oe);
  modport slave  (input din, din_oe);
endinterface

// File: rtl/bus_seq_monitor_bus_sync.sv
// bus_seq_monitor_bus_sync: STAGES-deep flop chain bringing an asynchronous input into clk
module bus_seq_monitor_bus_sync #(
  parameter int W      = 1,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < STAGES; i++) sync_d[i] = sync_q[i-1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '{default: '0};
    else sync_q <= sync_d;
  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/bus_seq_monitor.sv
// bus_seq_monitor: synchronise a counter bus, accept stable words and check the count sequence
module bus_seq_monitor import bus_seq_monitor_pkg::*; #(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 2,
  parameter int ERR_W       = DEF_ERR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_seq_monitor_if.slave  bus,
  input  logic              load_ok,
  input  logic              clear,
  output logic [WIDTH-1:0]  last_val,
  output logic              locked,
  output logic              word_stb,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt
);
  localparam int CW = $clog2(STABLE_CYC + 1);
  localparam logic [CW-1:0] STABLE = CW'(STABLE_CYC);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;
  logic [WIDTH-1:0] din_s, prev_q, last_val_q, last_val_d;
  logic             oe_s, same, acc, seq_ok;
  logic             done_q, done_d, locked_q, locked_d;
  logic             word_stb_q, word_stb_d, err_pulse_q, err_pulse_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  state_t           state_q, state_d;
  bus_seq_monitor_bus_sync #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_din_sync (
    .clk(clk), .rst_n(rst_n), .d(bus.din), .q(din_s)
  );
  bus_seq_monitor_bus_sync #(.W(1), .STAGES(SYNC_STAGES)) u_oe_sync (
    .clk(clk), .rst_n(rst_n), .d(bus.din_oe), .q(oe_s)
  );
  always_comb begin
    same        = oe_s && din_s == prev_q;
    cnt_d       = clear || !same ? CW'(1) : (cnt_q == STABLE ? STABLE : cnt_q + CW'(1));
    acc         = !clear && oe_s && cnt_d == STABLE && !(done_q && same);
    done_d      = !clear && oe_s && (acc || (done_q && same));
    seq_ok      = din_s == last_val_q + WIDTH'(ONE);
    state_d     = state_q;
    last_val_d  = last_val_q;
    err_cnt_d   = err_cnt_q;
    word_stb_d  = 1'b0;
    err_pulse_d = 1'b0;
    if (clear) begin
      state_d    = oe_s ? ACQUIRE : IDLE;
      last_val_d = '0;
      err_cnt_d  = '0;
    end else if (!oe_s) begin
      state_d = IDLE;
    end else if (acc) begin
      state_d     = TRACK;
      last_val_d  = din_s;
      word_stb_d  = 1'b1;
      err_pulse_d = state_q == TRACK && !seq_ok && !load_ok;
      err_cnt_d   = err_pulse_d && err_cnt_q != ERR_MAX ? err_cnt_q + ERR_W'(1) : err_cnt_q;
    end else if (state_q == IDLE) begin
      state_d = ACQUIRE;
    end
    locked_d = state_d == TRACK;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      prev_q      <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
      last_val_q  <= '0;
      locked_q    <= 1'b0;
      word_stb_q  <= 1'b0;
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prev_q      <= din_s;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
      last_val_q  <= last_val_d;
      locked_q    <= locked_d;
      word_stb_q  <= word_stb_d;
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  assign last_val  = last_val_q;
  assign locked    = locked_q;
  assign word_stb  = word_stb_q;
  assign err_pulse = err_pulse_q;
  assign err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_bus_seq_monitor.sv
// tb_bus_seq_monitor: directed stimulus checked against a cycle model and literal expectations
module tb_bus_seq_monitor;
  localparam int W = 8, S = 2, ST = 2, EW = 2;
  localparam int ERR_SAT = (1 << EW) - 1;
  logic clk = 1'b0, rst_n = 1'b0, load_ok = 1'b0, clear = 1'b0;
  logic [W-1:0] last_val;
  logic locked, word_stb, err_pulse;
  logic [EW-1:0] err_cnt;
  int n_chk = 0, n_pass = 0, n_stb = 0, n_err = 0;
  bus_seq_monitor_if #(.WIDTH(W)) bus ();
  bus_seq_monitor #(.WIDTH(W), .SYNC_STAGES(S), .STABLE_CYC(ST), .ERR_W(EW)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .load_ok(load_ok), .clear(clear),
    .last_val(last_val), .locked(locked), .word_stb(word_stb),
    .err_pulse(err_pulse), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  logic [W-1:0] hd [S+1];
  logic ho [S+1];
  int run, m_cnt;
  logic [W-1:0] m_last;
  logic m_trk, m_stb, m_err;
  always @(posedge clk or negedge rst_n) begin : model
    logic [W-1:0] ds;
    logic os, acc, bad;
    int r;
    if (!rst_n) begin
      hd <= '{default: '0};
      ho <= '{default: 1'b0};
      run <= 0;
      m_last <= '0;
      m_trk <= 1'b0;
      m_stb <= 1'b0;
      m_err <= 1'b0;
      m_cnt <= 0;
    end else begin
      ds = hd[S-1];
      os = ho[S-1];
      r = clear ? 1 : (os && ds == hd[S]) ? run + 1 : 1;
      acc = !clear && os && r == ST;
      bad = acc && m_trk && !load_ok && int'(ds) != (int'(m_last) + 1) % (1 << W);
      run <= r;
      m_stb <= acc;
      m_err <= bad;
      if (clear) begin
        m_last <= '0;
        m_cnt <= 0;
        m_trk <= 1'b0;
      end else if (!os) begin
        m_trk <= 1'b0;
      end else if (acc) begin
        m_last <= ds;
        m_trk <= 1'b1;
        if (bad) m_cnt <= m_cnt < ERR_SAT ? m_cnt + 1 : ERR_SAT;
      end
      for (int i = S; i > 0; i--) begin
        hd[i] <= hd[i-1];
        ho[i] <= ho[i-1];
      end
      hd[0] <= bus.din;
      ho[0] <= bus.din_oe;
    end
  end
  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic word(input logic [W-1:0] v, input int n);
    bus.din = v;
    cyc(n);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    if (rst_n) begin
      chk("model last_val", last_val, m_last);
      chk("model locked", locked, m_trk);
      chk("model word_stb", word_stb, m_stb);
      chk("model err_pulse", err_pulse, m_err);
      chk("model err_cnt", err_cnt, m_cnt);
      n_stb += int'(word_stb);
      n_err += int'(err_pulse);
    end
  end
  initial begin
    int s0, e0, lat;
    bus.din = '0;
    bus.din_oe = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    chk("reset last_val", last_val, 0);
    chk("reset locked", locked, 0);
    chk("reset err_cnt", err_cnt, 0);
    s0 = n_stb;
    bus.din = 8'h10;
    bus.din_oe = 1'b1;
    lat = 0;
    while (!word_stb && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("lock latency after first sample", lat - 1, 3);
    cyc(5);
    chk("lock stb count", n_stb - s0, 1);
    chk("lock last_val", last_val, 8'h10);
    chk("lock locked", locked, 1);
    chk("lock err_cnt", err_cnt, 0);
    s0 = n_stb;
    e0 = n_err;
    load_ok = 1'b1;
    word(8'hFD, 4);
    load_ok = 1'b0;
    word(8'hFE, 4);
    word(8'hFF, 4);
    word(8'h00, 4);
    word(8'h01, 4);
    cyc(4);
    chk("wrap stb count", n_stb - s0, 5);
    chk("wrap err count", n_err - e0, 0);
    chk("wrap last_val", last_val, 8'h01);
    load_ok = 1'b1;
    word(8'h05, 4);
    load_ok = 1'b0;
    e0 = n_err;
    word(8'h40, 4);
    chk("bad step err pulses", n_err - e0, 1);
    chk("bad step err_cnt", err_cnt, 1);
    load_ok = 1'b1;
    word(8'h80, 4);
    chk("load err pulses", n_err - e0, 1);
    chk("load last_val", last_val, 8'h80);
    chk("load err_cnt", err_cnt, 1);
    word(8'h06, 4);
    load_ok = 1'b0;
    s0 = n_stb;
    e0 = n_err;
    word(8'h33, 1);
    word(8'h07, 4);
    cyc(2);
    chk("glitch stb count", n_stb - s0, 1);
    chk("glitch err count", n_err - e0, 0);
    chk("glitch last_val", last_val, 8'h07);
    s0 = n_stb;
    bus.din = 8'h08;
    cyc(1);
    bus.din_oe = 1'b0;
    cyc(5);
    chk("drop locked", locked, 0);
    chk("drop last_val kept", last_val, 8'h07);
    chk("drop stb count", n_stb - s0, 0);
    s0 = n_stb;
    e0 = n_err;
    bus.din = 8'h22;
    bus.din_oe = 1'b1;
    cyc(6);
    chk("relock locked", locked, 1);
    chk("relock last_val", last_val, 8'h22);
    chk("relock stb count", n_stb - s0, 1);
    chk("relock err count", n_err - e0, 0);
    s0 = n_stb;
    bus.din = 8'h23;
    cyc(3);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear last_val", last_val, 0);
    chk("clear err_cnt", err_cnt, 0);
    chk("clear locked", locked, 0);
    chk("clear suppressed stb", n_stb - s0, 0);
    cyc(1);
    chk("reaccept word_stb", word_stb, 1);
    chk("reaccept last_val", last_val, 8'h23);
    chk("reaccept locked", locked, 1);
    e0 = n_err;
    word(8'h50, 4);
    word(8'h60, 4);
    word(8'h70, 4);
    word(8'h80, 4);
    word(8'h90, 4);
    cyc(2);
    chk("sat err pulses", n_err - e0, 5);
    chk("sat err_cnt", err_cnt, 3);
    bus.din = 8'h91;
    cyc(2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst last_val", last_val, 0);
    chk("async rst locked", locked, 0);
    chk("async rst word_stb", word_stb, 0);
    chk("async rst err_pulse", err_pulse, 0);
    chk("async rst err_cnt", err_cnt, 0);
    cyc(2);
    rst_n = 1'b1;
    s0 = n_stb;
    cyc(8);
    chk("post rst stb count", n_stb - s0, 1);
    chk("post rst last_val", last_val, 8'h91);
    chk("post rst locked", locked, 1);
    chk("post rst err_cnt", err_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
